serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller sitting directly upstream of the hw_sum full adder.
//  Latches two WIDTH-bit operands and a carry-in, then presents one bit pair per clock,
//  LSB first, on the full-adder inputs A/B/C. It consumes the full adder's S/Co outputs,
//  registers the carry back into C and shifts S into a result register.
//  Provides a start/busy/done handshake to the surrounding datapath.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); also the number of serial add cycles
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request an add; sampled only in IDLE
//  a_in     in   WIDTH  operand A, latched on the accepted start edge
//  b_in     in   WIDTH  operand B, latched on the accepted start edge
//  cin      in   1      carry-in, latched on the accepted start edge
//  fa_a     out  1      to hw_sum A: current A bit
//  fa_b     out  1      to hw_sum B: current B bit
//  fa_c     out  1      to hw_sum C: registered running carry
//  fa_s     in   1      from hw_sum S (combinational, same cycle)
//  fa_co    in   1      from hw_sum Co (combinational, same cycle)
//  busy     out  1      high while in RUN
//  done     out  1      one-cycle pulse; result valid
//  sum_out  out  WIDTH  result sum bits, held until next accepted start
//  cout     out  1      result carry-out, held until next accepted start
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all shift regs, carry_reg, bit_cnt, sum_out, cout,
//    busy, done and fa_* = 0. Reset asserted mid-RUN aborts the add; no done is issued.
//  - FSM: IDLE -> RUN (start=1) ; RUN -> DONE (edge on which bit_cnt==WIDTH-1) ; DONE -> IDLE.
//  - IDLE edge with start=1: a_sh<=a_in, b_sh<=b_in, carry_reg<=cin, bit_cnt<=0, sum_sh<=0.
//  - RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_reg (outputs driven from registers only).
//    Each RUN edge: sum_sh<={fa_s,sum_sh[WIDTH-1:1]}; carry_reg<=fa_co; a_sh,b_sh shift right by 1;
//    bit_cnt<=bit_cnt+1. bit_cnt is $clog2(WIDTH) bits wide and never wraps inside one op.
//  - On the RUN->DONE edge, sum_out<=next sum_sh value and cout<=fa_co (final carry).
//  - fa_a/fa_b/fa_c = 0 in IDLE and DONE.
//  - busy=1 exactly in RUN; done=1 exactly in DONE (one cycle).
//  - Latency: start sampled at edge 0; bits processed at edges 1..WIDTH; done high for the
//    cycle after edge WIDTH. Throughput: one add per WIDTH+2 cycles.
//  - Result: {cout,sum_out} == a_in + b_in + cin, exact (WIDTH+1 bits, no overflow loss).
//  - start while busy or in DONE: ignored, no queuing; operands are not re-latched.
//  - start held high continuously: a new add begins on the first IDLE edge after DONE.
//  - sum_out/cout change only on the RUN->DONE edge or on reset.
//  - fa_s/fa_co are assumed settled within one clock period of fa_* changing.
//    No combinational path from fa_s/fa_co to any output.
// TESTING (bench instantiates serial_add_ctrl + hw_sum, WIDTH=8 unless noted)
//  1. a=0xFF, b=0x01, cin=0, start 1 cycle -> busy 8 cycles, done at cycle 9,
//     sum_out=0x00, cout=1.
//  2. a=0x3C, b=0x42, cin=0 -> sum_out=0x7E, cout=0. Then a=0xA5, b=0x5A, cin=1 ->
//     sum_out=0x00, cout=1.
//  3. Start add 0x10+0x20; pulse start with a=0xFF at RUN cycle 3 -> ignored,
//     result 0x30, cout=0, single done pulse.
//  4. Drop rst_n at RUN cycle 4 of any add -> all outputs 0 immediately, no done;
//     next add completes correctly.
//  5. start tied high, 3 back-to-back ops -> done pulses spaced exactly WIDTH+2 cycles.
//  6. WIDTH=4: all 512 (a,b,cin) combos -> {cout,sum_out} == a+b+cin for every combo.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller driving an external full adder, LSB first.
// Latches operands on start, walks WIDTH bit pairs, reports {cout,sum_out} with a done pulse.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_s,
   input  logic             fa_co,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_out_q, sum_out_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      sum_sh_d  = sum_sh_q;
      sum_out_d = sum_out_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               a_sh_d    = a_in;
               b_sh_d    = b_in;
               carry_d   = cin;
               bit_cnt_d = '0;
               sum_sh_d  = '0;
            end
         end
         StRun: begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_co;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            if (bit_cnt_q == LastCnt) begin
               // Last bit: publish the result; counter holds so it never wraps.
               state_d   = StDone;
               sum_out_d = sum_sh_d;
               cout_d    = fa_co;
            end else begin
               bit_cnt_d = bit_cnt_q + CntW'(1);
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         sum_sh_q  <= '0;
         sum_out_q <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         sum_sh_q  <= sum_sh_d;
         sum_out_q <= sum_out_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign fa_a    = busy & a_sh_q[0];
   assign fa_b    = busy & b_sh_q[0];
   assign fa_c    = busy & carry_q;
   assign sum_out = sum_out_q;
   assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=4 instances, each closed through a full adder,
// checked against plain integer addition.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start = 1'b0, cin = 1'b0;
   logic [7:0] a_in = '0, b_in = '0;
   logic       fa_a, fa_b, fa_c, fa_s, fa_co, busy, done, cout;
   logic [7:0] sum_out;

   logic       start4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       fa_a4, fa_b4, fa_c4, fa_s4, fa_co4, busy4, done4, cout4;
   logic [3:0] sum4;

   int errors = 0;
   int checks = 0;

   // Full adder standing in for hw_sum.
   assign fa_s   = fa_a ^ fa_b ^ fa_c;
   assign fa_co  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
   assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_c4;
   assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_c4) | (fa_b4 & fa_c4);

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_co(fa_co),
      .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
   );

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
      .fa_a(fa_a4), .fa_b(fa_b4), .fa_c(fa_c4), .fa_s(fa_s4), .fa_co(fa_co4),
      .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
   );

   function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
      int s;
      s = int'(a) + int'(b) + int'(c);
      return 9'(s);
   endfunction

   // Runs one add on the WIDTH=8 instance for a fixed 14-cycle window after acceptance.
   // Cycle t=1 is the cycle after the accepting edge. Optionally pokes start at cycle poke_t.
   // fa_bad counts cycles whose fa_* bits differ from the arithmetic expectation;
   // hold_bad counts busy cycles where the previous result did not hold.
   task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input int poke_t, input logic [7:0] poke_a,
                           output logic [8:0] res, output int busy_n, output int lat,
                           output int done_n, output int fa_bad, output int hold_bad);
      logic [8:0] prev;
      int         k, mask, exp_c;
      busy_n = 0; lat = 0; done_n = 0; fa_bad = 0; hold_bad = 0;
      @(negedge clk);
      prev = {cout, sum_out};
      a_in = a; b_in = b; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 1; t <= 14; t++) begin
         if (busy === 1'b1) begin
            k     = busy_n;
            mask  = (1 << k) - 1;
            exp_c = (((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> k) & 1;
            if (k < 8) begin
               if (fa_a !== a[k] || fa_b !== b[k] || fa_c !== exp_c[0]) fa_bad++;
            end
            if ({cout, sum_out} !== prev) hold_bad++;
            busy_n++;
         end else if ({fa_a, fa_b, fa_c} !== 3'b000) begin
            fa_bad++;
         end
         if (done === 1'b1) begin
            done_n++;
            if (lat == 0) lat = t;
         end
         if (t == poke_t) begin
            start = 1'b1;
            a_in  = poke_a;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      res = {cout, sum_out};
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, fa_a, fa_b, fa_c, cout, sum_out} !== 13'd0) begin
         errors++;
         $display("FAIL reset8_in_reset: got %b required 0",
                  {busy, done, fa_a, fa_b, fa_c, cout, sum_out});
      end
      checks++;
      if ({busy4, done4, fa_a4, fa_b4, fa_c4, cout4, sum4} !== 9'd0) begin
         errors++;
         $display("FAIL reset4_in_reset: got %b required 0",
                  {busy4, done4, fa_a4, fa_b4, fa_c4, cout4, sum4});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, cout, sum_out} !== 11'd0) begin
         errors++;
         $display("FAIL reset8_after_release: got %b required 0", {busy, done, cout, sum_out});
      end
   endtask

   task automatic test_directed();
      logic [7:0] av[3] = '{8'hFF, 8'h3C, 8'hA5};
      logic [7:0] bv[3] = '{8'h01, 8'h42, 8'h5A};
      logic       cv[3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] want[3] = '{9'h100, 9'h07E, 9'h100};
      logic [8:0] res;
      int         bn, lat, dn, fb, hb;
      for (int i = 0; i < 3; i++) begin
         run_add8(av[i], bv[i], cv[i], 0, 8'h00, res, bn, lat, dn, fb, hb);
         checks++;
         if (res !== want[i]) begin
            errors++;
            $display("FAIL directed_%0d_result: got %h required %h", i, res, want[i]);
         end
         checks++;
         if (bn != 8 || lat != 9 || dn != 1) begin
            errors++;
            $display("FAIL directed_%0d_timing: busy=%0d done_at=%0d pulses=%0d required 8/9/1",
                     i, bn, lat, dn);
         end
         checks++;
         if (fb != 0 || hb != 0) begin
            errors++;
            $display("FAIL directed_%0d_fa_bits: fa_bad=%0d hold_bad=%0d required 0/0",
                     i, fb, hb);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [8:0] res;
      int         bn, lat, dn, fb, hb;
      run_add8(8'h10, 8'h20, 1'b0, 3, 8'hFF, res, bn, lat, dn, fb, hb);
      checks++;
      if (res !== 9'h030) begin
         errors++;
         $display("FAIL ignore_start_result: got %h required 030", res);
      end
      checks++;
      if (dn != 1 || lat != 9 || fb != 0) begin
         errors++;
         $display("FAIL ignore_start_pulse: pulses=%0d done_at=%0d fa_bad=%0d required 1/9/0",
                  dn, lat, fb);
      end
   endtask

   task automatic test_reset_midrun();
      logic [8:0] res;
      int         bn, lat, dn, fb, hb, spurious;
      run_add8(8'h12, 8'h34, 1'b0, 0, 8'h00, res, bn, lat, dn, fb, hb);
      checks++;
      if (res !== 9'h046) begin
         errors++;
         $display("FAIL pre_reset_result: got %h required 046", res);
      end
      @(negedge clk);
      a_in = 8'hF0; b_in = 8'h0F; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: got %b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, fa_a, fa_b, fa_c, cout, sum_out} !== 13'd0) begin
         errors++;
         $display("FAIL midrun_reset_outputs: got %b required 0",
                  {busy, done, fa_a, fa_b, fa_c, cout, sum_out});
      end
      spurious = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0) spurious++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL midrun_no_done: got %0d done cycles required 0", spurious);
      end
      run_add8(8'hC3, 8'h3D, 1'b1, 0, 8'h00, res, bn, lat, dn, fb, hb);
      checks++;
      if (res !== 9'h101 || lat != 9) begin
         errors++;
         $display("FAIL post_reset_add: got %h at %0d required 101 at 9", res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] av[3], bv[3];
      logic       cv[3];
      int         t_done[3];
      int         idx;
      for (int i = 0; i < 3; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
         cv[i] = 1'($urandom);
      end
      @(negedge clk);
      a_in = av[0]; b_in = bv[0]; cin = cv[0]; start = 1'b1;
      idx = 0;
      for (int cyc = 0; cyc < 60 && idx < 3; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            checks++;
            if ({cout, sum_out} !== ref_add8(av[idx], bv[idx], cv[idx])) begin
               errors++;
               $display("FAIL b2b_result_%0d: got %h required %h", idx, {cout, sum_out},
                        ref_add8(av[idx], bv[idx], cv[idx]));
            end
            t_done[idx] = cyc;
            idx++;
            if (idx < 3) begin
               a_in = av[idx]; b_in = bv[idx]; cin = cv[idx];
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checks++;
      if (idx != 3) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d done pulses required 3", idx);
      end else begin
         checks++;
         if (t_done[1] - t_done[0] != 10 || t_done[2] - t_done[1] != 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d required 10,10",
                     t_done[1] - t_done[0], t_done[2] - t_done[1]);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      logic       c;
      logic [8:0] res;
      int         bn, lat, dn, fb, hb;
      for (int i = 0; i < 30; i++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
         run_add8(a, b, c, 0, 8'h00, res, bn, lat, dn, fb, hb);
         checks++;
         if (res !== ref_add8(a, b, c) || lat != 9 || dn != 1 || fb != 0 || hb != 0) begin
            errors++;
            $display("FAIL random_%0d: %h+%h+%0d got %h lat=%0d pulses=%0d fa_bad=%0d required %h",
                     i, a, b, c, res, lat, dn, fb, ref_add8(a, b, c));
         end
      end
   endtask

   task automatic test_w4_exhaustive();
      int  want;
      int  bad;
      logic seen;
      bad = 0;
      @(negedge clk);
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0;
               seen = 1'b0;
               for (int t = 0; t < 12 && !seen; t++) begin
                  @(negedge clk);
                  if (done4 === 1'b1) seen = 1'b1;
               end
               want = a + b + c;
               checks++;
               if (!seen || {cout4, sum4} !== 5'(want)) begin
                  errors++;
                  bad++;
                  if (bad <= 10)
                     $display("FAIL w4_%0d_%0d_%0d: got %h done=%b required %h",
                              a, b, c, {cout4, sum4}, seen, 5'(want));
               end
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      test_w4_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
